peak_ar_master: RTL and testbench
=================================

# peak_ar_master

Debug-side initiator for the core's `AR_*` access port, the register-file and CSR debug bus. It accepts read/write commands on a valid/ready channel and drives `AR_EN`/`AR_WR`/`AR_AD`/`AR_DI`. It samples `AR_DO` after a fixed read latency and returns each result on a valid/ready response channel. It sits between the host debug transport (UART/JTAG bridge) and the core, and holds `AR_EN` only for the cycles of each access, so the core's own register-file writes are blocked as briefly as possible.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from `AR_EN`/`AR_AD` presented to `AR_DO` valid. Legal range 1..7; out of range raises an elaboration `$error`.
- `BURST_W`, default 4: width of `CMD_LEN`.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  command offered.
- `CMD_READY`  out  1  command accepted when high with `CMD_VALID` at a rising edge.
- `CMD_WR`  in  1  1 = write, 0 = read.
- `CMD_AD`  in  16  target address (`[15:8]` = space, e.g. 0x10 = register file).
- `CMD_DI`  in  32  write data.
- `CMD_LEN`  in  `BURST_W`  read beats minus 1 (burst build only).
- `RSP_VALID`  out  1  response available.
- `RSP_READY`  in  1  response consumed.
- `RSP_DO`  out  32  read data; 0 for write acknowledges.
- `RSP_LAST`  out  1  final response of a command.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `AR_EN`, `AR_WR`  out  1  access strobe and write qualifier.
- `AR_AD`  out  16  access address.
- `AR_DI`  out  32  access write data.
- `AR_DO`  in  32  read data from the core.

## Operation
- States: IDLE, WR, RD, RSP.
- IDLE:
  - `CMD_READY`=1; all other outputs are 0.
  - On handshake, the block latches `CMD_WR`, `CMD_AD`, `CMD_DI` and beat count = `CMD_LEN`.
  - It then moves to WR if `CMD_WR`=1, otherwise to RD.
- WR:
  - Asserts `AR_EN`=1, `AR_WR`=1, `AR_AD`=addr, `AR_DI`=data for exactly 1 cycle.
  - Then moves to RSP with `RSP_DO`=0 and `RSP_LAST`=1.
  - Writes are always single-beat; `CMD_LEN` is ignored for writes.
- RD:
  - Asserts `AR_EN`=1, `AR_WR`=0, `AR_AD`=addr for `RD_LAT`+1 cycles, counted by a latency counter.
  - Captures `AR_DO` into `RSP_DO` at the edge that ends the last of those cycles, then moves to RSP.
  - `AR_DI` is held at 0 during reads.
- RSP:
  - `RSP_VALID`=1, and `AR_EN`=0 so the core may proceed.
  - `RSP_DO` and `RSP_LAST` hold stable until `RSP_READY`.
  - On handshake: if beats remain, decrement the count, increment addr by 1 and return to RD; otherwise go to IDLE.
- Address increment is 16-bit modulo: 0xFFFF → 0x0000.
- `RSP_LAST` = 1 on the final beat only.
- `AR_*`, `RSP_*`, `CMD_READY` and `BUSY` are all driven from registers; no combinational path from any input to any output.

## Timing
- Reset value of every output is 0, except `CMD_READY`, which is 1 one cycle after reset release (0 during reset).
- Command accepted at edge k:
  - `AR_EN` rises after edge k.
  - For a write, `AR_EN` falls after k+1, and `RSP_VALID` rises after k+1.
  - For a read, `AR_EN` is high from edge k to edge k+`RD_LAT`+1; `AR_DO` is sampled at k+`RD_LAT`+1, and `RSP_VALID` rises after that edge.
- Response handshake at edge m on the final beat → `CMD_READY`=1 after m; the next command can be accepted at m+1.
- Next burst beat: `AR_EN` re-asserts after m.
- `CMD_READY` is 0 in every non-IDLE state; a `CMD_VALID` held while busy is not consumed.
- `RST_N` low at any point, including mid-access with `AR_EN` high:
  - All outputs clear immediately and the state is IDLE.
  - No pending response is delivered after release.

## Configuration
- `PEAK_AR_BURST_EN` defined: `CMD_LEN` is honoured; a read produces `CMD_LEN`+1 beats at incrementing addresses.
- Not defined: the beat counter is removed and `CMD_LEN` is ignored. Every read is single-beat and `RSP_LAST` is 1 on every response.

## Test plan
- Write, `CMD_AD`=0x1005, `CMD_DI`=0xDEADBEEF → `AR_EN`=`AR_WR`=1 for exactly 1 cycle with `AR_AD`=0x1005, `AR_DI`=0xDEADBEEF; `RSP_VALID` the next cycle with `RSP_DO`=0, `RSP_LAST`=1.
- Read 0x1005, `RD_LAT`=1, model returns 0xDEADBEEF one cycle after the address → `AR_EN` high 2 cycles, `AR_WR`=0; `RSP_DO`=0xDEADBEEF, `RSP_LAST`=1.
- Burst build, read 0x101E with `CMD_LEN`=3, `RSP_READY` low for 5 cycles on beat 2:
  - Addresses are 0x101E, 0x101F, 0x1020, 0x1021; 4 responses, `RSP_LAST` on the 4th only.
  - During the stall, `RSP_DO` stays stable and `AR_EN`=0.
- Burst build, read 0xFFFF with `CMD_LEN`=1 → `AR_AD` 0xFFFF, then 0x0000.
- `RST_N` pulsed low while `AR_EN`=1 in RD → all outputs 0 immediately; `CMD_READY`=1 one cycle after release; no `RSP_VALID` until a new command.
- `CMD_VALID` held high with a second command during an outstanding read → `CMD_READY`=0 until the response handshake; the second command is accepted the cycle after it.

Source files
------------

// File: rtl/peak_ar_master.sv
// Debug-side initiator for the core AR_* register/CSR access port.
// Define PEAK_AR_BURST_EN to honour CMD_LEN as a multi-beat read burst.
module peak_ar_master #(
    parameter int RD_LAT  = 1,
    parameter int BURST_W = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic               CMD_WR,
    input  logic [15:0]        CMD_AD,
    input  logic [31:0]        CMD_DI,
    input  logic [BURST_W-1:0] CMD_LEN,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic [31:0]        RSP_DO,
    output logic               RSP_LAST,
    output logic               BUSY,
    output logic               AR_EN,
    output logic               AR_WR,
    output logic [15:0]        AR_AD,
    output logic [31:0]        AR_DI,
    input  logic [31:0]        AR_DO
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
        $error("peak_ar_master: RD_LAT must be in 1..7");
    end

    localparam logic [2:0] LAT_MAX = 3'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] rsp_do_d;
    logic        rsp_last_d;
    logic        last_beat;

    logic        cmd_ready_d;
    logic        busy_d;
    logic        ar_en_d;
    logic        ar_wr_d;
    logic [15:0] ar_ad_d;
    logic [31:0] ar_di_d;
    logic        rsp_valid_d;

    logic        cmd_fire;
    logic        rsp_fire;

`ifdef PEAK_AR_BURST_EN
    logic [BURST_W-1:0] beats_q, beats_d;

    assign last_beat = (beats_q == '0);
`else
    logic unused_len;

    assign unused_len = ^CMD_LEN;
    assign last_beat  = 1'b1;
`endif

    // Handshakes use only registered outputs, so no input reaches an output.
    assign cmd_fire = CMD_VALID && CMD_READY;
    assign rsp_fire = RSP_VALID && RSP_READY;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        lat_d      = lat_q;
        rsp_do_d   = RSP_DO;
        rsp_last_d = RSP_LAST;
`ifdef PEAK_AR_BURST_EN
        beats_d    = beats_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d  = CMD_AD;
                    data_d  = CMD_WR ? CMD_DI : 32'd0;
                    lat_d   = 3'd0;
                    state_d = CMD_WR ? WR : RD;
`ifdef PEAK_AR_BURST_EN
                    beats_d = CMD_WR ? '0 : CMD_LEN;
`endif
                end
            end
            WR: begin
                rsp_do_d   = 32'd0;
                rsp_last_d = 1'b1;
                state_d    = RSP;
            end
            RD: begin
                if (lat_q == LAT_MAX) begin
                    rsp_do_d   = AR_DO;
                    rsp_last_d = last_beat;
                    state_d    = RSP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RSP: begin
                if (rsp_fire) begin
                    rsp_do_d   = 32'd0;
                    rsp_last_d = 1'b0;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        lat_d   = 3'd0;
                        state_d = RD;
`ifdef PEAK_AR_BURST_EN
                        beats_d = beats_q - 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        ar_en_d     = (state_d == WR) || (state_d == RD);
        ar_wr_d     = (state_d == WR);
        ar_ad_d     = ar_en_d ? addr_d : 16'd0;
        ar_di_d     = ar_wr_d ? data_d : 32'd0;
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            addr_q    <= 16'd0;
            data_q    <= 32'd0;
            lat_q     <= 3'd0;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b0;
            AR_EN     <= 1'b0;
            AR_WR     <= 1'b0;
            AR_AD     <= 16'd0;
            AR_DI     <= 32'd0;
            RSP_VALID <= 1'b0;
            RSP_DO    <= 32'd0;
            RSP_LAST  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            lat_q     <= lat_d;
            CMD_READY <= cmd_ready_d;
            BUSY      <= busy_d;
            AR_EN     <= ar_en_d;
            AR_WR     <= ar_wr_d;
            AR_AD     <= ar_ad_d;
            AR_DI     <= ar_di_d;
            RSP_VALID <= rsp_valid_d;
            RSP_DO    <= rsp_do_d;
            RSP_LAST  <= rsp_last_d;
        end
    end

`ifdef PEAK_AR_BURST_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end
`endif

endmodule

// File: tb/tb_peak_ar_master.sv
// Scoreboard bench for peak_ar_master: directed commands, core stub on AR_*,
// decoupled monitor comparing AR accesses and responses against queues.
module tb_peak_ar_master;

    localparam int RD_LAT = 1;
    localparam int BW     = 4;

    logic          CLK;
    logic          RST_N;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_WR;
    logic [15:0]   CMD_AD;
    logic [31:0]   CMD_DI;
    logic [BW-1:0] CMD_LEN;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [31:0]   RSP_DO;
    logic          RSP_LAST;
    logic          BUSY;
    logic          AR_EN;
    logic          AR_WR;
    logic [15:0]   AR_AD;
    logic [31:0]   AR_DI;
    logic [31:0]   AR_DO;

    peak_ar_master #(
        .RD_LAT (RD_LAT),
        .BURST_W(BW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_WR   (CMD_WR),
        .CMD_AD   (CMD_AD),
        .CMD_DI   (CMD_DI),
        .CMD_LEN  (CMD_LEN),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_DO   (RSP_DO),
        .RSP_LAST (RSP_LAST),
        .BUSY     (BUSY),
        .AR_EN    (AR_EN),
        .AR_WR    (AR_WR),
        .AR_AD    (AR_AD),
        .AR_DI    (AR_DI),
        .AR_DO    (AR_DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Core stub: unwritten words read as C0DE_<addr>; data one cycle after address.
    bit [31:0] mem [0:65535];
    bit        wv  [0:65535];

    function automatic logic [31:0] rd_mem(input logic [15:0] a);
        if (wv[a]) return mem[a];
        return {16'hC0DE, a};
    endfunction

    always @(posedge CLK) begin
        if (AR_EN && AR_WR) begin
            mem[AR_AD] <= AR_DI;
            wv[AR_AD]  <= 1'b1;
        end
        AR_DO <= (AR_EN && !AR_WR) ? rd_mem(AR_AD) : 32'hBAD0BAD0;
    end

    typedef struct packed {
        logic        wr;
        logic [15:0] ad;
        logic [31:0] di;
        logic [7:0]  len;
    } acc_t;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rsp_cnt = 0;
    int hs_edge = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected none", nm);
    endtask

    task automatic exp_wr(input logic [15:0] ad, input logic [31:0] di);
        acc_q.push_back('{wr: 1'b1, ad: ad, di: di, len: 8'd1});
        rsp_q.push_back('{d: 32'd0, last: 1'b1});
    endtask

    task automatic exp_rd(input logic [15:0] ad, input logic [31:0] d,
                          input logic last);
        acc_q.push_back('{wr: 1'b0, ad: ad, di: 32'd0, len: 8'(RD_LAT + 1)});
        rsp_q.push_back('{d: d, last: last});
    endtask

    // Monitor: AR access framing and response scoreboard.
    initial begin
        acc_t        a;
        rsp_t        r;
        logic        prev;
        int          run;
        int          elen;
        logic        hv;
        logic [31:0] hd;
        logic        hl;
        prev = 1'b0;
        run  = 0;
        elen = 0;
        hv   = 1'b0;
        hd   = 32'd0;
        hl   = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev = 1'b0;
                run  = 0;
                hv   = 1'b0;
            end else begin
                if (AR_EN && !prev) begin
                    if (acc_q.size() == 0) begin
                        fail("unexpected_access");
                    end else begin
                        a = acc_q.pop_front();
                        chk("ar_wr", 32'(AR_WR), 32'(a.wr));
                        chk("ar_ad", 32'(AR_AD), 32'(a.ad));
                        chk("ar_di", AR_DI, a.di);
                        elen = int'(a.len);
                    end
                    run = 1;
                end else if (AR_EN) begin
                    run++;
                end
                if (!AR_EN && prev) begin
                    chk("ar_en_len", 32'(run), 32'(elen));
                    chk("rsp_after_access", 32'(RSP_VALID), 32'd1);
                end
                prev = AR_EN;
                if (RSP_VALID) begin
                    chk("ar_en_in_rsp", 32'(AR_EN), 32'd0);
                    if (hv) begin
                        chk("stall_do", RSP_DO, hd);
                        chk("stall_last", 32'(RSP_LAST), 32'(hl));
                    end
                    if (RSP_READY) begin
                        if (rsp_q.size() == 0) begin
                            fail("unexpected_response");
                        end else begin
                            r = rsp_q.pop_front();
                            chk("rsp_do", RSP_DO, r.d);
                            chk("rsp_last", 32'(RSP_LAST), 32'(r.last));
                        end
                        rsp_cnt++;
                        hs_edge = cyc + 1;
                    end
                end
                hv = RSP_VALID && !RSP_READY;
                hd = RSP_DO;
                hl = RSP_LAST;
            end
        end
    end

    // Leaves CMD_VALID high on return (1 time unit after the accepting edge).
    task automatic issue(input logic wr, input logic [15:0] ad,
                         input logic [31:0] di, input logic [BW-1:0] len,
                         output int acc_edge);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        CMD_WR    = wr;
        CMD_AD    = ad;
        CMD_DI    = di;
        CMD_LEN   = len;
        CMD_VALID = 1'b1;
        while (!ok && n < 50) begin
            @(negedge CLK);
            ok = CMD_READY;
            @(posedge CLK);
            n++;
        end
        #1;
        acc_edge = cyc;
        if (!ok) begin
            fail("cmd_accept");
        end else begin
            chk("ar_en_after_accept", 32'(AR_EN), 32'd1);
            chk("busy_after_accept", 32'(BUSY), 32'd1);
            chk("ready_after_accept", 32'(CMD_READY), 32'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((acc_q.size() != 0 || rsp_q.size() != 0 || BUSY) && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 300) fail("drain");
        else chk("idle_ready", 32'(CMD_READY), 32'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {CMD_READY, RSP_VALID, RSP_LAST, BUSY, AR_EN, AR_WR,
                 26'd0}, 32'd0);
        chk({nm, "_ad_do"}, {AR_AD, 16'd0} | RSP_DO, 32'd0);
        chk({nm, "_di"}, AR_DI, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        int n;
        int base;
        logic acc;
        RST_N     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_WR    = 1'b0;
        CMD_AD    = 16'd0;
        CMD_DI    = 32'd0;
        CMD_LEN   = '0;
        RSP_READY = 1'b1;
        #2 RST_N = 1'b0;
        #1 chk_all_zero("reset_async");
        repeat (3) @(posedge CLK);
        #1 chk_all_zero("reset_held");
        @(negedge CLK);
        RST_N = 1'b1;
        #1 chk("ready_at_release", 32'(CMD_READY), 32'd0);
        @(posedge CLK);
        #1 chk("ready_after_release", 32'(CMD_READY), 32'd1);

        // Single write
        exp_wr(16'h1005, 32'hDEADBEEF);
        issue(1'b1, 16'h1005, 32'hDEADBEEF, '0, k);
        CMD_VALID = 1'b0;
        drain();

        // Single read back
        exp_rd(16'h1005, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 16'h1005, 32'd0, '0, k);
        CMD_VALID = 1'b0;
        drain();

        // Burst read with a 5-cycle stall on beat 2
`ifdef PEAK_AR_BURST_EN
        exp_rd(16'h101E, 32'hC0DE101E, 1'b0);
        exp_rd(16'h101F, 32'hC0DE101F, 1'b0);
        exp_rd(16'h1020, 32'hC0DE1020, 1'b0);
        exp_rd(16'h1021, 32'hC0DE1021, 1'b1);
`else
        exp_rd(16'h101E, 32'hC0DE101E, 1'b1);
`endif
        base = rsp_cnt;
        issue(1'b0, 16'h101E, 32'd0, 4'd3, k);
        CMD_VALID = 1'b0;
        n = 0;
        while (rsp_cnt < base + 1 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 100) fail("first_beat");
        RSP_READY = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RSP_READY = 1'b1;
        drain();

        // Address wrap
`ifdef PEAK_AR_BURST_EN
        exp_rd(16'hFFFF, 32'hC0DEFFFF, 1'b0);
        exp_rd(16'h0000, 32'hC0DE0000, 1'b1);
`else
        exp_rd(16'hFFFF, 32'hC0DEFFFF, 1'b1);
`endif
        issue(1'b0, 16'hFFFF, 32'd0, 4'd1, k);
        CMD_VALID = 1'b0;
        drain();

        // Reset while AR_EN is high in RD
        acc_q.push_back('{wr: 1'b0, ad: 16'h1010, di: 32'd0, len: 8'(RD_LAT + 1)});
        issue(1'b0, 16'h1010, 32'd0, '0, k);
        CMD_VALID = 1'b0;
        @(posedge CLK);
        #1 chk("ar_en_before_abort", 32'(AR_EN), 32'd1);
        RST_N = 1'b0;
        #1 chk_all_zero("reset_mid_read");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1 chk("ready_after_abort", 32'(CMD_READY), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("no_rsp_after_abort", 32'(RSP_VALID), 32'd0);
            @(posedge CLK);
            #1;
        end
        chk("acc_q_empty_after_abort", 32'(acc_q.size()), 32'd0);

        // Second command held valid during an outstanding read
        exp_rd(16'h1005, 32'hDEADBEEF, 1'b1);
        exp_wr(16'h1006, 32'h12345678);
        base = rsp_cnt;
        issue(1'b0, 16'h1005, 32'd0, '0, k);
        CMD_WR = 1'b1;
        CMD_AD = 16'h1006;
        CMD_DI = 32'h12345678;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge CLK);
            if (CMD_READY) acc = 1'b1;
            else if (rsp_cnt == base) chk("ready_while_busy", 32'(CMD_READY), 32'd0);
            @(posedge CLK);
            n++;
        end
        #1;
        k2 = cyc;
        CMD_VALID = 1'b0;
        if (!acc) fail("second_accept");
        else chk("second_accept_edge", 32'(k2), 32'(hs_edge + 1));
        drain();
        chk("readback_1006", rd_mem(16'h1006), 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
